param_mem_arbiter: RTL and testbench
====================================

PARAM_MEM_ARBITER -- requirements
Module: param_mem_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_WIDTH, 8, data word width; ADDR_WIDTH, 8, address width; FIFO_DEPTH, 4, host write buffer entries (power of 2, >=2); STARVE_LIMIT, 8, cycles a pending write may wait before forced service.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_addr  in  ADDR_WIDTH  host write address
- wr_data  in  WORD_WIDTH  host write data
- wr_enable  in  1  one-cycle push strobe
- host_rd_req  in  1  one-cycle host read strobe
- host_rd_addr  in  ADDR_WIDTH  host read address, sampled with host_rd_req
- host_rd_busy  out  1  host read pending or in flight
- host_rd_valid  out  1  one-cycle strobe, host_rd_data valid
- host_rd_data  out  WORD_WIDTH  host read result
- dsp_rd_req  in  1  DSP read request
- dsp_rd_addr  in  ADDR_WIDTH  DSP read address
- dsp_rd_ready  out  1  DSP request accepted when req & ready
- dsp_rd_valid  out  1  one-cycle strobe, dsp_rd_data valid
- dsp_rd_data  out  WORD_WIDTH  DSP read result
- ram_addr  out  ADDR_WIDTH  single-port RAM address, registered
- ram_wdata  out  WORD_WIDTH  RAM write data, registered
- ram_we  out  1  RAM write enable, registered
- ram_rdata  in  WORD_WIDTH  RAM read data, valid 1 cycle after ram_addr
- wr_overflow  out  1  sticky: a write was dropped
- host_rd_err  out  1  sticky: host_rd_req arrived while host_rd_busy

Function
REQ-003 Exactly one RAM operation SHALL be granted per cycle; candidates: DSP read (D), host read (H), write drain (W).
REQ-004 Default priority SHALL be D > H > W.
REQ-005 H SHALL be eligible only when the write FIFO is empty (host read-after-write ordering).
REQ-006 Starvation counter SHALL increment each cycle the FIFO is non-empty and no pop occurs, clear on pop or when empty, and saturate at STARVE_LIMIT.
REQ-007 When counter == STARVE_LIMIT, W SHALL win that cycle and dsp_rd_ready SHALL be 0.
REQ-008 dsp_rd_ready SHALL otherwise be 1; D is accepted on any cycle with dsp_rd_req & dsp_rd_ready.
REQ-009 Granted operation SHALL appear on ram_addr/ram_we/ram_wdata the cycle after grant; ram_we=1 only for W.
REQ-010 Read result SHALL be presented 2 cycles after grant: dsp_rd_valid or host_rd_valid pulses with ram_rdata registered; pipeline tag selects destination.
REQ-011 Idle cycles SHALL drive ram_we=0; ram_addr holds its last value.
REQ-012 wr_enable SHALL push {wr_addr,wr_data}; push accepted if FIFO not full, or full with a pop in the same cycle.
REQ-013 Push into a full FIFO without same-cycle pop SHALL be dropped and set wr_overflow.
REQ-014 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-015 Simultaneous push and pop on an empty FIFO SHALL NOT bypass; the entry drains in a later cycle.
REQ-016 host_rd_req while idle SHALL capture host_rd_addr and set host_rd_busy next cycle; busy clears the cycle after host_rd_valid.
REQ-017 host_rd_req while busy SHALL be ignored and set host_rd_err.
REQ-018 Sticky flags SHALL clear only on reset.

Reset
REQ-019 While reset=1: FIFO empty, counter 0, no pending host read, read pipeline flushed, in-flight results discarded.
REQ-020 Reset outputs: ram_we 0, ram_addr 0, ram_wdata 0, host_rd_busy 0, host_rd_valid 0, dsp_rd_valid 0, host_rd_data 0, dsp_rd_data 0, wr_overflow 0, host_rd_err 0, dsp_rd_ready 1.
REQ-021 Inputs sampled during reset SHALL be ignored.

Verification
REQ-022 RAM model ram_rdata<=ram_addr; DSP read 0x05 accepted cycle t -> ram_addr=0x05 at t+1, dsp_rd_valid with 0x05 at t+2.
REQ-023 Write 0x0d<=0x5f, then host read 0x0d -> ram_we pulse with 0x0d/0x5f precedes host read grant; host_rd_valid returns model value, busy spans request to valid.
REQ-024 dsp_rd_req held high continuously, one write pushed -> dsp_rd_ready low exactly cycle STARVE_LIMIT (8) after push, write issued next cycle, DSP resumes.
REQ-025 5 pushes back-to-back with DSP saturating -> first 4 buffered, 5th dropped, wr_overflow=1; push at full with same-cycle pop accepted.
REQ-026 Second host_rd_req 1 cycle after first -> host_rd_err=1, exactly one host_rd_valid.
REQ-027 Reset asserted with host read and 2 writes in flight -> no valid strobes, no ram_we after reset, all outputs at REQ-020 values.

Source files
------------

// File: rtl/param_mem_arbiter.sv
// ---------------------------------------------------------------------------
// param_mem_arbiter
//
// Shares one single-port RAM between three requesters:
//   D - DSP reads (valid/ready handshake, highest default priority)
//   H - host reads (one outstanding, strobe-driven)
//   W - host writes, buffered in a small FIFO and drained when the RAM is free
// One RAM operation is granted per cycle. The default priority is D > H > W.
// H is held off while the write FIFO holds data, so a host read always sees
// earlier host writes. A starvation counter forces W once a buffered write has
// waited STARVE_LIMIT cycles. In that cycle dsp_rd_ready drops.
//
// Handshake semantics: a DSP read is accepted on any rising edge where
// dsp_rd_req & dsp_rd_ready. wr_enable and host_rd_req are single-cycle
// strobes with no back-pressure. The RAM result is returned as a one-cycle
// dsp_rd_valid / host_rd_valid pulse two cycles after the grant.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   wr_addr/wr_data/wr_enable           host write push
//   host_rd_req/host_rd_addr            host read request
//   host_rd_busy/host_rd_valid/host_rd_data   host read status and result
//   dsp_rd_req/dsp_rd_addr/dsp_rd_ready       DSP read request handshake
//   dsp_rd_valid/dsp_rd_data                  DSP read result
//   ram_addr/ram_wdata/ram_we/ram_rdata       registered RAM port
//   wr_overflow         sticky: a push was dropped because the FIFO was full
//   host_rd_err         sticky: host_rd_req arrived while a host read was busy
// ---------------------------------------------------------------------------
module param_mem_arbiter #(
    parameter int WORD_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  wr_enable,
    input  logic                  host_rd_req,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic                  host_rd_busy,
    output logic                  host_rd_valid,
    output logic [WORD_WIDTH-1:0] host_rd_data,
    input  logic                  dsp_rd_req,
    input  logic [ADDR_WIDTH-1:0] dsp_rd_addr,
    output logic                  dsp_rd_ready,
    output logic                  dsp_rd_valid,
    output logic [WORD_WIDTH-1:0] dsp_rd_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [WORD_WIDTH-1:0] ram_rdata,
    output logic                  wr_overflow,
    output logic                  host_rd_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int ENT_W = ADDR_WIDTH + WORD_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    // Host read tracker: WAIT = captured, not yet granted; FLIGHT = granted,
    // result still in the read pipeline.
    typedef enum logic [1:0] {
        HR_IDLE   = 2'd0,
        HR_WAIT   = 2'd1,
        HR_FLIGHT = 2'd2
    } host_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_DSP   = 2'd1,
        GNT_HOST  = 2'd2,
        GNT_WRITE = 2'd3
    } grant_t;

    // Write FIFO
    logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [STV_W-1:0] starve_q, starve_d;

    // Host read
    host_state_t           host_state_q, host_state_d;
    logic [ADDR_WIDTH-1:0] host_addr_q, host_addr_d;

    // RAM port and read pipeline tags
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ram_we_q, ram_we_d;
    logic                  s1_rd_valid_q, s1_rd_valid_d;
    logic                  s1_rd_host_q, s1_rd_host_d;
    logic                  dsp_rd_valid_q, dsp_rd_valid_d;
    logic                  host_rd_valid_q, host_rd_valid_d;

    // Sticky flags
    logic wr_overflow_q, wr_overflow_d;
    logic host_rd_err_q, host_rd_err_d;

    // Combinational helpers
    grant_t           grant;
    logic             fifo_empty;
    logic             fifo_full;
    logic             starve_hit;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        fifo_full  = (fifo_cnt_q == FULL_CNT);
        starve_hit = (starve_q == STARVE_MAX);
        head       = fifo_mem_q[rd_ptr_q];
        grant      = GNT_NONE;
        if (!reset) begin
            // The counter only reaches the limit while the FIFO holds data,
            // so a forced W always has an entry to drain.
            if (starve_hit) begin
                grant = GNT_WRITE;
            end else if (dsp_rd_req) begin
                grant = GNT_DSP;
            end else if ((host_state_q == HR_WAIT) && fifo_empty) begin
                grant = GNT_HOST;
            end else if (!fifo_empty) begin
                grant = GNT_WRITE;
            end
        end
        pop  = (grant == GNT_WRITE);
        // A push into a full FIFO is still accepted when the same cycle pops.
        // A push into an empty FIFO does not bypass to the RAM. It drains in
        // a later cycle.
        push = !reset && wr_enable && (!fifo_full || pop);
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        fifo_mem_d      = fifo_mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        fifo_cnt_d      = fifo_cnt_q;
        starve_d        = starve_q;
        host_state_d    = host_state_q;
        host_addr_d     = host_addr_q;
        ram_addr_d      = ram_addr_q;
        ram_wdata_d     = ram_wdata_q;
        ram_we_d        = 1'b0;
        s1_rd_valid_d   = 1'b0;
        s1_rd_host_d    = 1'b0;
        dsp_rd_valid_d  = 1'b0;
        host_rd_valid_d = 1'b0;
        wr_overflow_d   = wr_overflow_q;
        host_rd_err_d   = host_rd_err_q;

        // FIFO
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {wr_addr, wr_data};
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (!reset && wr_enable && fifo_full && !pop) begin
            wr_overflow_d = 1'b1;
        end

        // Starvation counter: counts cycles the head entry waits.
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (!starve_hit) begin
            starve_d = starve_q + 1'b1;
        end

        // Host read tracker
        case (host_state_q)
            HR_IDLE: begin
                if (host_rd_req) begin
                    host_state_d = HR_WAIT;
                    host_addr_d  = host_rd_addr;
                end
            end
            HR_WAIT: begin
                if (grant == GNT_HOST) begin
                    host_state_d = HR_FLIGHT;
                end
            end
            HR_FLIGHT: begin
                // Busy drops the cycle after the result strobe.
                if (host_rd_valid_q) begin
                    host_state_d = HR_IDLE;
                end
            end
            default: host_state_d = HR_IDLE;
        endcase
        if (host_rd_req && (host_state_q != HR_IDLE)) begin
            host_rd_err_d = 1'b1;
        end

        // RAM port. ram_addr holds its value on idle cycles.
        case (grant)
            GNT_DSP: begin
                ram_addr_d    = dsp_rd_addr;
                s1_rd_valid_d = 1'b1;
            end
            GNT_HOST: begin
                ram_addr_d    = host_addr_q;
                s1_rd_valid_d = 1'b1;
                s1_rd_host_d  = 1'b1;
            end
            GNT_WRITE: begin
                {ram_addr_d, ram_wdata_d} = head;
                ram_we_d                  = 1'b1;
            end
            default: ;
        endcase

        // The stage-2 tag lines up with ram_rdata for the read issued last cycle.
        dsp_rd_valid_d  = s1_rd_valid_q && !s1_rd_host_q;
        host_rd_valid_d = s1_rd_valid_q && s1_rd_host_q;
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fifo_cnt_q      <= '0;
            starve_q        <= '0;
            host_state_q    <= HR_IDLE;
            host_addr_q     <= '0;
            ram_addr_q      <= '0;
            ram_wdata_q     <= '0;
            ram_we_q        <= 1'b0;
            s1_rd_valid_q   <= 1'b0;
            s1_rd_host_q    <= 1'b0;
            dsp_rd_valid_q  <= 1'b0;
            host_rd_valid_q <= 1'b0;
            wr_overflow_q   <= 1'b0;
            host_rd_err_q   <= 1'b0;
        end else begin
            fifo_mem_q      <= fifo_mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fifo_cnt_q      <= fifo_cnt_d;
            starve_q        <= starve_d;
            host_state_q    <= host_state_d;
            host_addr_q     <= host_addr_d;
            ram_addr_q      <= ram_addr_d;
            ram_wdata_q     <= ram_wdata_d;
            ram_we_q        <= ram_we_d;
            s1_rd_valid_q   <= s1_rd_valid_d;
            s1_rd_host_q    <= s1_rd_host_d;
            dsp_rd_valid_q  <= dsp_rd_valid_d;
            host_rd_valid_q <= host_rd_valid_d;
            wr_overflow_q   <= wr_overflow_d;
            host_rd_err_q   <= host_rd_err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // The RAM registers its own read data. Passing ram_rdata through while the
    // valid strobe is high meets the two-cycle latency. The data is held at 0
    // between strobes so that reset and idle values stay defined.
    assign dsp_rd_data   = dsp_rd_valid_q  ? ram_rdata : '0;
    assign host_rd_data  = host_rd_valid_q ? ram_rdata : '0;
    assign dsp_rd_valid  = dsp_rd_valid_q;
    assign host_rd_valid = host_rd_valid_q;
    assign dsp_rd_ready  = reset || !starve_hit;
    assign host_rd_busy  = (host_state_q != HR_IDLE);
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_we        = ram_we_q;
    assign wr_overflow   = wr_overflow_q;
    assign host_rd_err   = host_rd_err_q;

endmodule

// File: tb/tb_param_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_param_mem_arbiter
//
// Directed bench for param_mem_arbiter. The RAM model returns the address it
// was given one cycle earlier, so every expected read value is the read
// address. A negedge monitor checks DSP read data against dsp_exp_q and RAM
// writes against wr_exp_q. The main thread applies hand-traced cycle vectors.
// ---------------------------------------------------------------------------
module tb_param_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_addr, wr_data;
  logic       wr_enable;
  logic       host_rd_req;
  logic [7:0] host_rd_addr;
  logic       host_rd_busy, host_rd_valid;
  logic [7:0] host_rd_data;
  logic       dsp_rd_req;
  logic [7:0] dsp_rd_addr;
  logic       dsp_rd_ready, dsp_rd_valid;
  logic [7:0] dsp_rd_data;
  logic [7:0] ram_addr, ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic       wr_overflow, host_rd_err;

  int n_vec = 0;
  int n_err = 0;
  int n_hvalid = 0;
  int n_dvalid = 0;
  int n_we = 0;

  logic [7:0]  dsp_exp_q[$];
  logic [15:0] wr_exp_q[$];

  param_mem_arbiter #(
    .WORD_WIDTH(8),
    .ADDR_WIDTH(8),
    .FIFO_DEPTH(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_enable(wr_enable),
    .host_rd_req(host_rd_req),
    .host_rd_addr(host_rd_addr),
    .host_rd_busy(host_rd_busy),
    .host_rd_valid(host_rd_valid),
    .host_rd_data(host_rd_data),
    .dsp_rd_req(dsp_rd_req),
    .dsp_rd_addr(dsp_rd_addr),
    .dsp_rd_ready(dsp_rd_ready),
    .dsp_rd_valid(dsp_rd_valid),
    .dsp_rd_data(dsp_rd_data),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .wr_overflow(wr_overflow),
    .host_rd_err(host_rd_err)
  );

  // ---- clock / RAM model ----
  always #5 clk = ~clk;

  always_ff @(posedge clk) ram_rdata <= ram_addr;

  // ---- checker ----
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_enable    = 1'b0;
    wr_addr      = 8'h00;
    wr_data      = 8'h00;
    host_rd_req  = 1'b0;
    host_rd_addr = 8'h00;
    dsp_rd_req   = 1'b0;
    dsp_rd_addr  = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_we"},     32'(ram_we),        0);
    check({tag, "_ram_addr"},   32'(ram_addr),      0);
    check({tag, "_ram_wdata"},  32'(ram_wdata),     0);
    check({tag, "_busy"},       32'(host_rd_busy),  0);
    check({tag, "_hvalid"},     32'(host_rd_valid), 0);
    check({tag, "_dvalid"},     32'(dsp_rd_valid),  0);
    check({tag, "_hdata"},      32'(host_rd_data),  0);
    check({tag, "_ddata"},      32'(dsp_rd_data),   0);
    check({tag, "_overflow"},   32'(wr_overflow),   0);
    check({tag, "_rd_err"},     32'(host_rd_err),   0);
    check({tag, "_dsp_ready"},  32'(dsp_rd_ready),  1);
  endtask

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    logic [7:0]  exp_d;
    logic [15:0] exp_w;
    if (reset) begin
      dsp_exp_q.delete();
    end else begin
      if (dsp_rd_valid) begin
        n_dvalid++;
        if (dsp_exp_q.size() == 0) begin
          check("dsp_unexpected_valid", 32'(dsp_rd_valid), 0);
        end else begin
          exp_d = dsp_exp_q.pop_front();
          check("dsp_data", 32'(dsp_rd_data), 32'(exp_d));
        end
      end
      if (dsp_rd_req && dsp_rd_ready) dsp_exp_q.push_back(dsp_rd_addr);
      if (ram_we) begin
        n_we++;
        if (wr_exp_q.size() == 0) begin
          check("wr_unexpected", 32'(ram_we), 0);
        end else begin
          exp_w = wr_exp_q.pop_front();
          check("wr_entry", 32'({ram_addr, ram_wdata}), 32'(exp_w));
        end
      end
      if (host_rd_valid) n_hvalid++;
    end
  end

  // ---- directed stimulus ----
  initial begin
    reset = 1'b1;
    clear_inputs();

    // Reset values, with inputs active during reset that must be ignored.
    tick();
    wr_enable = 1'b1; wr_addr = 8'h11; wr_data = 8'h22;
    host_rd_req = 1'b1; host_rd_addr = 8'h33;
    dsp_rd_req = 1'b1; dsp_rd_addr = 8'h44;
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    clear_inputs();
    tick();
    check("rst_ign_busy", 32'(host_rd_busy), 0);
    tick();
    check("rst_ign_we", 32'(ram_we), 0);
    check("rst_ign_dvalid", 32'(dsp_rd_valid), 0);

    // A: DSP read 0x05 accepted at t, ram_addr at t+1, valid/data at t+2.
    check("a_ready", 32'(dsp_rd_ready), 1);
    dsp_rd_req = 1'b1; dsp_rd_addr = 8'h05;
    tick();
    dsp_rd_req = 1'b0;
    check("a_ram_addr", 32'(ram_addr), 8'h05);
    check("a_ram_we", 32'(ram_we), 0);
    check("a_dvalid_early", 32'(dsp_rd_valid), 0);
    tick();
    check("a_dvalid", 32'(dsp_rd_valid), 1);
    check("a_ddata", 32'(dsp_rd_data), 8'h05);
    tick();
    check("a_dvalid_pulse", 32'(dsp_rd_valid), 0);
    tick();

    // B: write 0x0d<=0x5f, then host read of 0x0d.
    wr_enable = 1'b1; wr_addr = 8'h0d; wr_data = 8'h5f;
    wr_exp_q.push_back(16'h0d5f);
    tick();
    wr_enable = 1'b0;
    check("b_busy_idle", 32'(host_rd_busy), 0);
    host_rd_req = 1'b1; host_rd_addr = 8'h0d;
    tick();
    host_rd_req = 1'b0;
    check("b_we", 32'(ram_we), 1);
    check("b_waddr", 32'(ram_addr), 8'h0d);
    check("b_wdata", 32'(ram_wdata), 8'h5f);
    check("b_busy_set", 32'(host_rd_busy), 1);
    tick();
    check("b_rd_we", 32'(ram_we), 0);
    check("b_rd_addr", 32'(ram_addr), 8'h0d);
    check("b_busy_mid", 32'(host_rd_busy), 1);
    check("b_hvalid_early", 32'(host_rd_valid), 0);
    tick();
    check("b_hvalid", 32'(host_rd_valid), 1);
    check("b_hdata", 32'(host_rd_data), 8'h0d);
    check("b_busy_at_valid", 32'(host_rd_busy), 1);
    tick();
    check("b_busy_clear", 32'(host_rd_busy), 0);
    check("b_hvalid_pulse", 32'(host_rd_valid), 0);
    tick();

    // C: second host_rd_req one cycle after the first.
    n_hvalid = 0;
    check("c_err_before", 32'(host_rd_err), 0);
    host_rd_req = 1'b1; host_rd_addr = 8'h21;
    tick();
    check("c_busy", 32'(host_rd_busy), 1);
    host_rd_req = 1'b1; host_rd_addr = 8'h33;
    tick();
    host_rd_req = 1'b0;
    check("c_err_set", 32'(host_rd_err), 1);
    check("c_ram_addr", 32'(ram_addr), 8'h21);
    tick();
    check("c_hvalid", 32'(host_rd_valid), 1);
    check("c_hdata", 32'(host_rd_data), 8'h21);
    for (int i = 0; i < 5; i++) tick();
    check("c_one_valid", 32'(n_hvalid), 1);
    check("c_busy_end", 32'(host_rd_busy), 0);
    check("c_err_sticky", 32'(host_rd_err), 1);

    // D: DSP held high, one write pushed at cycle p. The entry waits cycles
    //    p+1..p+8, the counter hits 8 at p+9 (ready low), and the write hits
    //    the RAM at p+10.
    wr_exp_q.push_back(16'h40aa);
    for (int k = 0; k <= 11; k++) begin
      check($sformatf("d_ready_%0d", k), 32'(dsp_rd_ready), (k == 9) ? 32'd0 : 32'd1);
      if (k == 10) begin
        check("d_we", 32'(ram_we), 1);
        check("d_waddr", 32'(ram_addr), 8'h40);
        check("d_wdata", 32'(ram_wdata), 8'haa);
      end
      dsp_rd_req  = 1'b1;
      dsp_rd_addr = 8'(8'h80 + k);
      wr_enable   = (k == 0);
      wr_addr     = 8'h40;
      wr_data     = 8'haa;
      tick();
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();

    // E: 5 back-to-back pushes with the DSP saturating. 0x54 is dropped.
    //    At the forced drain (e+9) a push into the full FIFO is accepted.
    wr_exp_q.push_back(16'h5060);
    wr_exp_q.push_back(16'h5161);
    wr_exp_q.push_back(16'h5262);
    wr_exp_q.push_back(16'h5363);
    wr_exp_q.push_back(16'h5565);
    for (int k = 0; k <= 9; k++) begin
      if (k == 4) check("e_ovf_before", 32'(wr_overflow), 0);
      if (k == 5) check("e_ovf_set", 32'(wr_overflow), 1);
      if (k == 9) check("e_ready_starve", 32'(dsp_rd_ready), 0);
      dsp_rd_req  = 1'b1;
      dsp_rd_addr = 8'(8'ha0 + k);
      wr_enable   = (k <= 4) || (k == 9);
      wr_addr     = (k == 9) ? 8'h55 : 8'(8'h50 + k);
      wr_data     = (k == 9) ? 8'h65 : 8'(8'h60 + k);
      tick();
    end
    clear_inputs();
    check("e_first_drain_we", 32'(ram_we), 1);
    check("e_first_drain_addr", 32'(ram_addr), 8'h50);
    for (int i = 0; i < 8; i++) tick();
    check("e_drained", 32'(wr_exp_q.size()), 0);
    check("e_ovf_sticky", 32'(wr_overflow), 1);

    // F: reset with a host read and two writes pending and DSP reads in flight.
    dsp_rd_req = 1'b1; dsp_rd_addr = 8'h90;
    wr_enable = 1'b1; wr_addr = 8'h70; wr_data = 8'h71;
    host_rd_req = 1'b1; host_rd_addr = 8'h77;
    tick();
    dsp_rd_addr = 8'h91;
    wr_addr = 8'h72; wr_data = 8'h73;
    host_rd_req = 1'b0;
    tick();
    check("f_busy_pre", 32'(host_rd_busy), 1);
    reset = 1'b1;
    host_rd_req = 1'b1;
    tick();
    check_reset_outputs("f_rst");
    tick();
    reset = 1'b0;
    clear_inputs();
    n_hvalid = 0;
    n_dvalid = 0;
    n_we     = 0;
    for (int i = 0; i < 12; i++) tick();
    check("f_no_hvalid", 32'(n_hvalid), 0);
    check("f_no_dvalid", 32'(n_dvalid), 0);
    check("f_no_we", 32'(n_we), 0);
    check_reset_outputs("f_post");

    check("end_dsp_q_empty", 32'(dsp_exp_q.size()), 0);
    check("end_wr_q_empty", 32'(wr_exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
